// File: rtl/rs_syndrome_calc_if.sv
// Symbol-in / syndrome-out bundle for rs_syndrome_calc.
// The master drives symbols in; the slave returns syndromes and the Euclid START pulse.
interface rs_syndrome_calc_if #(
    parameter int unsigned NSYN = 4
);
    logic                  IN_VALID;
    logic                  IN_SOF;
    logic [3:0]            IN_SYM;
    logic                  IN_READY;
    logic [4*NSYN-1:0]     SYNDROMES;
    logic                  SYN_VALID;
    logic                  SYN_ZERO;
    logic                  START;

    modport master (
        output IN_VALID, IN_SOF, IN_SYM,
        input  IN_READY, SYNDROMES, SYN_VALID, SYN_ZERO, START
    );

    modport slave (
        input  IN_VALID, IN_SOF, IN_SYM,
        output IN_READY, SYNDROMES, SYN_VALID, SYN_ZERO, START
    );
endinterface

// File: rtl/rs_syndrome_calc.sv
// RS(15,11) syndrome stage over GF(16), x^4+x+1: Horner accumulation of S1..S_NSYN.
// Optional macro SYN_ZERO_BYPASS_EN suppresses START when every syndrome is zero.
module rs_syndrome_calc #(
    parameter int unsigned N    = 15,
    parameter int unsigned NSYN = 4
) (
    input logic               CLK,
    input logic               RESET,
    rs_syndrome_calc_if.slave bus
);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q;
    logic [NSYN-1:0][3:0] acc_q;
    logic [NSYN-1:0][3:0] acc_upd;
    logic [NSYN-1:0][3:0] syn_q;
    logic                 syn_zero_q;
    logic                 accept;
    logic                 last_sym;
    logic                 in_ready;
    logic                 syn_valid;
    logic                 start;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ {2'b00, t[3], t[3]};
        end
        return p;
    endfunction

    function automatic logic [3:0] alpha_pow(input int unsigned e);
        logic [3:0] p;
        p = 4'h1;
        for (int unsigned k = 0; k < e; k++) p = gf_mul(p, 4'h2);
        return p;
    endfunction

    assign accept   = bus.IN_VALID && (state_q == ST_ACCUM);
    assign last_sym = accept && !bus.IN_SOF && (count_q == CW'(N - 1));

    // Multipliers are by constants once unrolled, so each reduces to an XOR network.
    always_comb begin
        acc_upd = '0;
        for (int unsigned j = 0; j < NSYN; j++) begin
            acc_upd[j] = gf_mul(acc_q[j], alpha_pow(j + 1)) ^ bus.IN_SYM;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_ACCUM;
            count_q    <= '0;
            acc_q      <= '0;
            syn_q      <= '0;
            syn_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (bus.IN_SOF) begin
                            acc_q   <= {NSYN{bus.IN_SYM}};
                            count_q <= CW'(1);
                        end else begin
                            acc_q   <= acc_upd;
                            count_q <= count_q + CW'(1);
                            if (last_sym) begin
                                syn_q      <= acc_upd;
                                syn_zero_q <= (acc_upd == '0);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    acc_q   <= '0;
                    count_q <= '0;
                end
                default: begin
                    acc_q   <= '0;
                    count_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_d   = ST_ACCUM;
        in_ready  = 1'b0;
        syn_valid = 1'b0;
        start     = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                state_d  = last_sym ? ST_DONE : ST_ACCUM;
            end
            ST_DONE: begin
                syn_valid = 1'b1;
`ifdef SYN_ZERO_BYPASS_EN
                start     = !syn_zero_q;
`else
                start     = 1'b1;
`endif
                state_d   = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    assign bus.IN_READY  = in_ready;
    assign bus.SYNDROMES = syn_q;
    assign bus.SYN_VALID = syn_valid;
    assign bus.SYN_ZERO  = syn_zero_q;
    assign bus.START     = start;
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc: table of whole blocks plus hand-written corner sequences.
module tb_rs_syndrome_calc;
    logic CLK = 1'b0;
    logic RESET;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   last_pulse_cyc = 0;
    int   pulse_gap = 0;

    rs_syndrome_calc_if #(.NSYN(4)) bus ();

    rs_syndrome_calc #(.N(15), .NSYN(4)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.SYN_VALID === 1'b1) begin
            pulses         = pulses + 1;
            pulse_gap      = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
        end
    end

    typedef struct {
        string       name;
        logic [59:0] syms;     // r14 in [59:56] ... r0 in [3:0]
        int          gap;
        logic [15:0] exp_syn;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_start(input logic zero);
`ifdef SYN_ZERO_BYPASS_EN
        return !zero;
`else
        return 1'b1;
`endif
    endfunction

    // Present one symbol and hold it until the DUT takes it; returns at posedge+1.
    task automatic send_sym(input logic [3:0] s, input logic sof);
        bit taken;
        taken = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.IN_SOF   = sof;
        bus.IN_SYM   = s;
        for (int k = 0; k < 4 && !taken; k++) begin
            taken = bus.IN_READY;
            @(posedge CLK);
            #1;
        end
        if (!taken) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_block(input logic [59:0] syms, input int gap, input bit hold);
        for (int i = 14; i >= 0; i--) begin
            send_sym(syms[4*i +: 4], (i == 14));
            if (i != 0 && gap > 0) begin
                bus.IN_VALID = 1'b0;
                bus.IN_SOF   = 1'b1;   // must be ignored while IN_VALID is low
                repeat (gap) @(posedge CLK);
                #1;
            end
        end
        if (!hold) begin
            bus.IN_VALID = 1'b0;
            bus.IN_SOF   = 1'b0;
        end
    endtask

    task automatic check_done(input string n, input logic [15:0] es, input logic ez);
        chk({n, "_syn_valid"}, 32'(bus.SYN_VALID), 32'd1);
        chk({n, "_start"}, 32'(bus.START), 32'(exp_start(ez)));
        chk({n, "_syndromes"}, 32'(bus.SYNDROMES), 32'(es));
        chk({n, "_syn_zero"}, 32'(bus.SYN_ZERO), 32'(ez));
        chk({n, "_ready_low"}, 32'(bus.IN_READY), 32'd0);
    endtask

    task automatic check_after(input string n, input logic [15:0] es, input logic ez, input int ep);
        @(posedge CLK);
        #1;
        chk({n, "_valid_drop"}, 32'(bus.SYN_VALID), 32'd0);
        chk({n, "_start_drop"}, 32'(bus.START), 32'd0);
        chk({n, "_ready_back"}, 32'(bus.IN_READY), 32'd1);
        chk({n, "_syn_hold"}, 32'(bus.SYNDROMES), 32'(es));
        chk({n, "_zero_hold"}, 32'(bus.SYN_ZERO), 32'(ez));
        chk({n, "_pulse_cnt"}, 32'(pulses), 32'(ep));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        vecs[0] = '{"zero",     60'h000000000000000, 0, 16'h0000, 1'b1};
        vecs[1] = '{"r14",      60'h100000000000000, 0, 16'hEFD9, 1'b0};
        vecs[2] = '{"r0",       60'h000000000000001, 0, 16'h1111, 1'b0};
        vecs[3] = '{"r0_gap",   60'h000000000000001, 3, 16'h1111, 1'b0};
        vecs[4] = '{"r13",      60'h010000000000000, 0, 16'hBAED, 1'b0};
        vecs[5] = '{"all_ones", 60'h111111111111111, 0, 16'h0000, 1'b1};
        vecs[6] = '{"r0_5",     60'h000000000000005, 0, 16'h5555, 1'b0};
        vecs[7] = '{"r14_r0",   60'h100000000000001, 1, 16'hFEC8, 1'b0};

        RESET        = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.IN_SOF   = 1'b0;
        bus.IN_SYM   = 4'h0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("rst_syndromes", 32'(bus.SYNDROMES), 32'd0);
        chk("rst_syn_valid", 32'(bus.SYN_VALID), 32'd0);
        chk("rst_start", 32'(bus.START), 32'd0);
        chk("rst_syn_zero", 32'(bus.SYN_ZERO), 32'd0);
        chk("rst_ready", 32'(bus.IN_READY), 32'd1);

        for (int v = 0; v < 8; v++) begin
            p0 = pulses;
            send_block(vecs[v].syms, vecs[v].gap, 1'b0);
            chk({vecs[v].name, "_no_early_pulse"}, 32'(pulses), 32'(p0));
            check_done(vecs[v].name, vecs[v].exp_syn, vecs[v].exp_zero);
            check_after(vecs[v].name, vecs[v].exp_syn, vecs[v].exp_zero, p0 + 1);
            repeat (2) @(posedge CLK);
            #1;
        end

        // Partial block abandoned by a fresh IN_SOF.
        p0 = pulses;
        send_sym(4'h3, 1'b1);
        for (int i = 0; i < 6; i++) send_sym(4'(i + 5), 1'b0);
        send_block(60'h100000000000000, 0, 1'b0);
        check_done("resof", 16'hEFD9, 1'b0);
        check_after("resof", 16'hEFD9, 1'b0, p0 + 1);

        // Reset after 10 accepts, then a clean zero block.
        p0 = pulses;
        send_sym(4'h7, 1'b1);
        for (int i = 0; i < 9; i++) send_sym(4'hA, 1'b0);
        bus.IN_VALID = 1'b0;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("abort_syndromes", 32'(bus.SYNDROMES), 32'd0);
        chk("abort_ready", 32'(bus.IN_READY), 32'd1);
        repeat (6) @(posedge CLK);
        #1;
        chk("abort_no_pulse", 32'(pulses), 32'(p0));
        send_block(60'h000000000000000, 0, 1'b0);
        check_done("clean", 16'h0000, 1'b1);
        check_after("clean", 16'h0000, 1'b1, p0 + 1);

        // Back-to-back blocks with IN_VALID held high through DONE.
        p0 = pulses;
        send_block(60'h100000000000000, 0, 1'b1);
        check_done("b2b_first", 16'hEFD9, 1'b0);
        send_block(60'h000000000000001, 0, 1'b0);
        check_done("b2b_second", 16'h1111, 1'b0);
        check_after("b2b", 16'h1111, 1'b0, p0 + 2);
        chk("b2b_pulse_spacing", 32'(pulse_gap), 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
- Upstream stage of the RS(15,11) decoder over GF(2^4), primitive polynomial x^4+x+1.
- Accepts one received codeword as 15 serial 4-bit symbols, highest-degree coefficient r14 first.
- Computes syndromes S1..S4 by Horner accumulation, S_j = r(alpha^j).
- Presents the syndromes and a one-cycle START pulse to the Euclid controller/datapath that follows.

Parameters:
- N, 15, code length in symbols (symbols per block); legal 2..15.
- NSYN, 4, number of syndromes (2t); one accumulator per syndrome, constant multipliers alpha^1..alpha^NSYN.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  IN_SYM is valid this cycle
- IN_SOF  in  1  qualifies IN_VALID: this symbol is r(N-1), first of a block
- IN_SYM  in  4  received symbol
- IN_READY  out  1  block can accept a symbol this cycle
- SYNDROMES  out  4*NSYN  {S_NSYN,...,S2,S1}, S1 in bits [3:0]
- SYN_VALID  out  1  one-cycle strobe: SYNDROMES updated
- SYN_ZERO  out  1  all syndromes zero for the last completed block
- START  out  1  one-cycle pulse to the Euclid stage

Behaviour:
- Reset (RESET=1 at a rising edge):
  - state ACCUM, count=0, accumulators=0.
  - SYNDROMES=0, SYN_VALID=0, START=0, SYN_ZERO=0, IN_READY=1 the following cycle.
  - Reset mid-block discards the partial block silently.
- Accept: a symbol is accepted on a rising edge with IN_VALID=1 and IN_READY=1.
- Accumulation on accept: acc_j <= gf_mul_const(acc_j, alpha^j) XOR IN_SYM, j=1..NSYN.
  - All arithmetic is GF(16): addition is XOR, constant multiplies are combinational XOR networks, no carries.
  - alpha powers: a1=2, a2=4, a3=8, a4=3.
- State ACCUM:
  - IN_READY=1.
  - count increments on each accept.
  - When the accepting symbol has count==N-1: load SYNDROMES from the updated accumulator values and go to DONE.
- IN_SOF with an accept in ACCUM:
  - Forces acc_j <= IN_SYM for all j and count <= 1.
  - Any partial block is dropped.
  - IN_SOF at count 0 is the normal case.
  - IN_SOF is ignored when IN_VALID=0.
- State DONE, exactly one cycle:
  - IN_READY=0, SYN_VALID=1, START=1.
  - Accumulators and count are cleared.
  - Next state is ACCUM unconditionally.
- Latency: SYN_VALID/START rise in the cycle after the Nth symbol is accepted. Throughput is N+1 cycles per block minimum.
- SYNDROMES and SYN_ZERO hold their values until the next DONE. SYN_ZERO=1 iff every S_j==0.
- IN_VALID during DONE is not accepted (IN_READY=0). The upstream source must hold the symbol until the next cycle.
- Gaps: IN_VALID low for any number of cycles stalls accumulation with no state change.
- Illegal state encodings recover to ACCUM with count=0.

Optional Feature:
- SYN_ZERO_BYPASS_EN
  - Defined: in DONE with all syndromes zero, START stays 0 (the Euclid stage is not launched). SYN_VALID and SYN_ZERO still assert as normal.
  - Undefined: START pulses in every DONE cycle regardless of syndrome value. SYN_ZERO is still produced.

Test Plan:
1. Reset, then 15 accepts all IN_SYM=0 with IN_SOF on the first -> one cycle later SYN_VALID=1, START=1 (0 if SYN_ZERO_BYPASS_EN), SYNDROMES=0x0000, SYN_ZERO=1; IN_READY=0 that cycle only.
2. r14=1 first, then 14 zeros -> SYNDROMES=0xEFD9 (S1=9, S2=13, S3=15, S4=14), SYN_ZERO=0, START=1 for exactly one cycle.
3. 14 zeros then r0=1 -> SYNDROMES=0x1111.
   - Repeat with IN_VALID gaps of 3 idle cycles between symbols -> identical result; SYN_VALID only after the 15th accept.
4. Send 7 symbols of a block, then assert IN_SOF with IN_SYM=1 followed by 14 zeros -> partial block discarded, SYNDROMES=0xEFD9.
5. Assert RESET after 10 accepted symbols, then send a clean all-zero block -> no SYN_VALID for the aborted block; SYNDROMES=0x0000 after the clean block.
6. Hold IN_VALID=1 continuously across two back-to-back blocks (case 2, then case 3) -> the symbol presented during DONE is not consumed; second result 0x1111; SYN_VALID pulses exactly twice, 16 cycles apart.
